// File: rtl/jtcps15_qsnd_vol.sv
// QSound output volume control: button-driven 16-step gain with auto-repeat,
// applied to stereo samples through one shared, time-multiplexed multiplier.
module jtcps15_qsnd_vol #(
  parameter int unsigned REPEAT = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        sample_in,
  output logic [15:0] left_out,
  output logic [15:0] right_out,
  output logic        sample_out,
  output logic [3:0]  vol_level
);

  localparam int unsigned CW       = (REPEAT > 2) ? $clog2(REPEAT) : 1;
  localparam int unsigned RPT_LAST = (REPEAT > 0) ? REPEAT - 1 : 0;
  localparam logic [3:0]  LVL_RST  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL_L, S_MUL_R, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            up_prev_q, dn_prev_q;
  logic [CW-1:0]   up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [3:0]      level_q, level_d;
  logic [15:0]     xl_q, xl_d, xr_q, xr_d, g_q, g_d;
  logic [15:0]     lres_q, lres_d, rres_q, rres_d;
  logic [15:0]     lout_q, lout_d, rout_q, rout_d;
  logic            sout_q, sout_d;

  logic            up_rise, dn_rise, only_up, only_dn, up_rep, dn_rep;
  logic            step_up, step_dn;
  logic [15:0]     mul_x;
  logic signed [32:0] prod, shf;
  logic [15:0]     mul_sat;

  // Q2.14 gain, 2 dB per level, level 12 is unity
  function automatic logic [15:0] gain(input logic [3:0] l);
    case (l)
      4'd0:    gain = 16'd0;
      4'd1:    gain = 16'd1301;
      4'd2:    gain = 16'd1638;
      4'd3:    gain = 16'd2063;
      4'd4:    gain = 16'd2597;
      4'd5:    gain = 16'd3269;
      4'd6:    gain = 16'd4115;
      4'd7:    gain = 16'd5181;
      4'd8:    gain = 16'd6523;
      4'd9:    gain = 16'd8211;
      4'd10:   gain = 16'd10338;
      4'd11:   gain = 16'd13014;
      4'd12:   gain = 16'd16384;
      4'd13:   gain = 16'd20626;
      4'd14:   gain = 16'd25968;
      default: gain = 16'd32690;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       sat16 = 16'h7fff;
    else if (v < -33'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

  // Shared multiplier: left operand in S_MUL_L, right operand in S_MUL_R
  always_comb begin
    mul_x   = (state_q == S_MUL_R) ? xr_q : xl_q;
    prod    = 33'($signed(mul_x)) * 33'($signed({1'b0, g_q}));
    shf     = prod >>> 14;
    mul_sat = sat16(shf);
  end

  // Button edge detection, hold auto-repeat and level saturation
  always_comb begin
    up_rise = vol_up & ~up_prev_q;
    dn_rise = vol_down & ~dn_prev_q;
    only_up = vol_up & ~vol_down;
    only_dn = vol_down & ~vol_up;
    up_rep  = (REPEAT != 0) && only_up && !up_rise && (up_cnt_q == CW'(RPT_LAST));
    dn_rep  = (REPEAT != 0) && only_dn && !dn_rise && (dn_cnt_q == CW'(RPT_LAST));
    step_up = only_up & (up_rise | up_rep);
    step_dn = only_dn & (dn_rise | dn_rep);

    up_cnt_d = (REPEAT == 0 || !only_up || step_up) ? '0 : up_cnt_q + CW'(1);
    dn_cnt_d = (REPEAT == 0 || !only_dn || step_dn) ? '0 : dn_cnt_q + CW'(1);

    level_d = level_q;
    if (step_up && level_q != 4'd15)     level_d = level_q + 4'd1;
    else if (step_dn && level_q != 4'd0) level_d = level_q - 4'd1;
  end

  // Sample pipeline FSM; S_DONE publishes results and can accept a new sample
  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    g_d     = g_q;
    lres_d  = lres_q;
    rres_d  = rres_q;
    lout_d  = lout_q;
    rout_d  = rout_q;
    sout_d  = 1'b0;
    case (state_q)
      S_MUL_L: begin
        lres_d  = mul_sat;
        state_d = S_MUL_R;
      end
      S_MUL_R: begin
        rres_d  = mul_sat;
        state_d = S_DONE;
      end
      default: begin
        if (state_q == S_DONE) begin
          lout_d = lres_q;
          rout_d = rres_q;
          sout_d = 1'b1;
        end
        state_d = S_IDLE;
        if (sample_in) begin
          xl_d    = left_in;
          xr_d    = right_in;
          g_d     = gain(level_q);
          state_d = S_MUL_L;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      up_cnt_q  <= '0;
      dn_cnt_q  <= '0;
      level_q   <= LVL_RST;
      xl_q      <= '0;
      xr_q      <= '0;
      g_q       <= '0;
      lres_q    <= '0;
      rres_q    <= '0;
      lout_q    <= '0;
      rout_q    <= '0;
      sout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      up_prev_q <= vol_up;
      dn_prev_q <= vol_down;
      up_cnt_q  <= up_cnt_d;
      dn_cnt_q  <= dn_cnt_d;
      level_q   <= level_d;
      xl_q      <= xl_d;
      xr_q      <= xr_d;
      g_q       <= g_d;
      lres_q    <= lres_d;
      rres_q    <= rres_d;
      lout_q    <= lout_d;
      rout_q    <= rout_d;
      sout_q    <= sout_d;
    end
  end

  assign left_out   = lout_q;
  assign right_out  = rout_q;
  assign sample_out = sout_q;
  assign vol_level  = level_q;

endmodule
